acq_seq_ctrl: RTL and testbench

Acquisition sequencer for the dual-ADC capture path. Arms on software enable and accepts an internal (1 s tick) or external trigger. Opens a fixed-length write window to both ADC FIFOs, drains them in lock-step into the readout fabric, then applies a holdoff before re-arming. Runs in the CLKB domain; its write window replaces the free-running trigger-sequence flag feeding both FIFO write enables.

---
 rtl/acq_seq_ctrl_if.sv | 28 ++
 rtl/acq_seq_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_acq_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_seq_ctrl_if.sv
// ============================================================================
// Module   : acq_seq_ctrl_if
// Brief    : FIFO-side signal bundle between the acquisition sequencer and the
//            dual ADC capture FIFOs (write window, common pop, empty/full flags).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface acq_seq_ctrl_if;
    logic fifo_ef1;
    logic fifo_ef2;
    logic fifo_ff1;
    logic fifo_ff2;
    logic wr_window;
    logic rd_en;

    modport master (
        input  fifo_ef1, fifo_ef2, fifo_ff1, fifo_ff2,
        output wr_window, rd_en
    );

    modport slave (
        output fifo_ef1, fifo_ef2, fifo_ff1, fifo_ff2,
        input  wr_window, rd_en
    );
endinterface

`default_nettype wire

// File: rtl/acq_seq_ctrl.sv
// ============================================================================
// Module   : acq_seq_ctrl
// Brief    : Dual-ADC acquisition sequencer: arm, trigger, capture window,
//            lock-step drain, holdoff. Optional macro ACQ_SINGLE_SHOT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acq_seq_ctrl #(
    parameter int WIN_W    = 12,
    parameter int HOLD_W   = 16,
    parameter int DRAIN_TO = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_arm_en,
    input  logic              i_clr,
    input  logic [1:0]        i_trig_sel,
    input  logic              i_trig_int,
    input  logic              i_trig_ext,
    input  logic [WIN_W-1:0]  i_win_len,
    input  logic [HOLD_W-1:0] i_holdoff,
    input  logic [39:0]       i_time_in,
    acq_seq_ctrl_if.master    fifo,
    output logic              o_busy,
    output logic [2:0]        o_state,
    output logic [15:0]       o_evt_cnt,
    output logic [39:0]       o_evt_time,
    output logic [7:0]        o_miss_cnt,
    output logic              o_ovf_flag,
    output logic              o_err_flag
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    localparam int TO_W = $clog2(DRAIN_TO + 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_empty_d;
    logic              r_wr_window;
    logic [15:0]       r_evt_cnt;
    logic [39:0]       r_evt_time;
    logic [7:0]        r_miss_cnt;
    logic              r_ovf_flag;
    logic              r_err_flag;
    logic              r_ext_s1;
    logic              r_ext_s2;
    logic              r_ext_s3;
    logic              r_ext_pulse;

    logic              w_trig;
    logic              w_accept;
    logic              w_miss;
    logic              w_both_empty;
    logic              w_one_empty;
    logic              w_to_last;
    logic              w_hold_done;
    logic              w_rearm_ok;
    logic [2:0]        w_hold_exit;
    logic              w_rd_en;

    // External trigger: two-stage synchroniser, edge detect, registered pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_s1    <= 1'b0;
            r_ext_s2    <= 1'b0;
            r_ext_s3    <= 1'b0;
            r_ext_pulse <= 1'b0;
        end else begin
            r_ext_s1    <= i_trig_ext;
            r_ext_s2    <= r_ext_s1;
            r_ext_s3    <= r_ext_s2;
            r_ext_pulse <= r_ext_s2 & ~r_ext_s3;
        end
    end

    always_comb begin
        w_trig = 1'b0;
        case (i_trig_sel)
            2'b00:   w_trig = i_trig_int;
            2'b01:   w_trig = r_ext_pulse;
            2'b10:   w_trig = i_trig_int | r_ext_pulse;
            default: w_trig = 1'b0;
        endcase
    end

    assign w_both_empty = fifo.fifo_ef1 & fifo.fifo_ef2;
    assign w_one_empty  = fifo.fifo_ef1 ^ fifo.fifo_ef2;
    assign w_to_last    = (r_to_cnt == TO_W'(DRAIN_TO - 1));
    assign w_hold_done  = (r_state == S_HOLDOFF) && (r_hold_cnt == HOLD_W'(1));
    assign w_accept     = (r_state == S_ARMED) && i_arm_en && w_trig;
    // A trigger coinciding with ARMED entry is neither missed nor accepted
    assign w_miss       = w_trig && (r_state != S_ARMED) && (w_next != S_ARMED);

`ifdef ACQ_SINGLE_SHOT_EN
    logic r_rearm_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rearm_ok <= 1'b1;
        end else if (!i_arm_en) begin
            r_rearm_ok <= 1'b1;
        end else if (w_hold_done) begin
            r_rearm_ok <= 1'b0;
        end
    end

    assign w_rearm_ok  = r_rearm_ok;
    assign w_hold_exit = S_IDLE;
`else
    assign w_rearm_ok  = 1'b1;
    assign w_hold_exit = i_arm_en ? S_ARMED : S_IDLE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_arm_en && w_rearm_ok) w_next = S_ARMED;
            end
            S_ARMED: begin
                if (!i_arm_en)   w_next = S_IDLE;
                else if (w_trig) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (r_win_cnt == WIN_W'(1)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Two empty cycles in a row absorb the FIFO flag update latency
                if (w_both_empty && r_empty_d)     w_next = S_HOLDOFF;
                else if (w_one_empty && w_to_last) w_next = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (w_hold_done) w_next = w_hold_exit;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_state = r_state;
        o_busy  = (r_state != S_IDLE) && (r_state != S_ARMED);
        w_rd_en = ((r_state == S_CAPTURE) || (r_state == S_DRAIN))
                  && !fifo.fifo_ef1 && !fifo.fifo_ef2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_to_cnt    <= '0;
            r_empty_d   <= 1'b0;
            r_wr_window <= 1'b0;
            r_evt_cnt   <= '0;
            r_evt_time  <= '0;
            r_miss_cnt  <= '0;
            r_ovf_flag  <= 1'b0;
            r_err_flag  <= 1'b0;
        end else begin
            r_wr_window <= (w_next == S_CAPTURE);
            r_empty_d   <= (r_state == S_DRAIN) && w_both_empty;

            if (w_accept) begin
                r_win_cnt  <= (i_win_len == '0) ? WIN_W'(1) : i_win_len;
                r_evt_time <= i_time_in;
            end else if (r_state == S_CAPTURE) begin
                r_win_cnt <= r_win_cnt - WIN_W'(1);
            end

            if ((r_state == S_DRAIN) && w_one_empty) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end

            if ((r_state == S_DRAIN) && (w_next == S_HOLDOFF)) begin
                r_hold_cnt <= (i_holdoff == '0) ? HOLD_W'(1) : i_holdoff;
            end else if (r_state == S_HOLDOFF) begin
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end

            // Clear wins over history but not over an event in the same cycle
            if (i_clr) begin
                r_evt_cnt <= {15'd0, w_accept};
            end else if (w_accept) begin
                r_evt_cnt <= r_evt_cnt + 16'd1;
            end

            if (i_clr) begin
                r_miss_cnt <= {7'd0, w_miss};
            end else if (w_miss && (r_miss_cnt != 8'hFF)) begin
                r_miss_cnt <= r_miss_cnt + 8'd1;
            end

            r_ovf_flag <= (r_ovf_flag & ~i_clr)
                          | ((r_state == S_CAPTURE) && (fifo.fifo_ff1 || fifo.fifo_ff2));
            r_err_flag <= (r_err_flag & ~i_clr)
                          | ((r_state == S_DRAIN) && w_one_empty && w_to_last);
        end
    end

    assign fifo.wr_window = r_wr_window;
    assign fifo.rd_en     = w_rd_en;
    assign o_evt_cnt      = r_evt_cnt;
    assign o_evt_time     = r_evt_time;
    assign o_miss_cnt     = r_miss_cnt;
    assign o_ovf_flag     = r_ovf_flag;
    assign o_err_flag     = r_err_flag;

endmodule

`default_nettype wire

// File: tb/tb_acq_seq_ctrl.sv
// ============================================================================
// Module   : tb_acq_seq_ctrl
// Brief    : Directed self-checking bench for acq_seq_ctrl (DRAIN_TO = 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acq_seq_ctrl;

    localparam int WIN_W  = 12;
    localparam int HOLD_W = 16;

`ifdef ACQ_SINGLE_SHOT_EN
    localparam logic [2:0] EXP_AFTER_HOLD = 3'd0;
`else
    localparam logic [2:0] EXP_AFTER_HOLD = 3'd1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arm_en;
    logic              clr;
    logic [1:0]        trig_sel;
    logic              trig_int;
    logic              trig_ext;
    logic [WIN_W-1:0]  win_len;
    logic [HOLD_W-1:0] holdoff;
    logic [39:0]       time_in;
    logic              busy;
    logic [2:0]        state;
    logic [15:0]       evt_cnt;
    logic [39:0]       evt_time;
    logic [7:0]        miss_cnt;
    logic              ovf_flag;
    logic              err_flag;

    int n_cmp = 0;
    int n_bad = 0;

    acq_seq_ctrl_if u_if ();

    acq_seq_ctrl #(
        .WIN_W    (WIN_W),
        .HOLD_W   (HOLD_W),
        .DRAIN_TO (16)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_arm_en   (arm_en),
        .i_clr      (clr),
        .i_trig_sel (trig_sel),
        .i_trig_int (trig_int),
        .i_trig_ext (trig_ext),
        .i_win_len  (win_len),
        .i_holdoff  (holdoff),
        .i_time_in  (time_in),
        .fifo       (u_if),
        .o_busy     (busy),
        .o_state    (state),
        .o_evt_cnt  (evt_cnt),
        .o_evt_time (evt_time),
        .o_miss_cnt (miss_cnt),
        .o_ovf_flag (ovf_flag),
        .o_err_flag (err_flag)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic rearm();
        arm_en = 1'b0;
        step(1);
        arm_en = 1'b1;
        step(1);
    endtask

    initial begin
        rst_n = 1'b0; arm_en = 1'b0; clr = 1'b0; trig_sel = 2'b00;
        trig_int = 1'b0; trig_ext = 1'b0; win_len = '0; holdoff = '0;
        time_in = '0;
        u_if.fifo_ef1 = 1'b1; u_if.fifo_ef2 = 1'b1;
        u_if.fifo_ff1 = 1'b0; u_if.fifo_ff2 = 1'b0;
        step(2);
        chk("rst_state", state, 3'd0);
        chk("rst_wr", u_if.wr_window, 1'b0);
        chk("rst_rd", u_if.rd_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_evt", evt_cnt, 16'd0);
        chk("rst_miss", miss_cnt, 8'd0);
        chk("rst_flags", {ovf_flag, err_flag}, 2'b00);
        chk("rst_time", evt_time, 40'd0);
        rst_n = 1'b1;
        step(1);

        // Internal trigger, 1024-cycle window, holdoff 10
        win_len = 12'd1024; holdoff = 16'd10; arm_en = 1'b1;
        step(1);
        chk("t1_armed", state, 3'd1);
        time_in = 40'h12_3456_789A; trig_int = 1'b1;
        step(1);
        trig_int = 1'b0; time_in = 40'h99;
        chk("t1_capture", state, 3'd2);
        chk("t1_wr_first", u_if.wr_window, 1'b1);
        chk("t1_evt", evt_cnt, 16'd1);
        chk("t1_time", evt_time, 40'h12_3456_789A);
        chk("t1_busy", busy, 1'b1);
        step(1023);
        chk("t1_wr_last", u_if.wr_window, 1'b1);
        step(1);
        chk("t1_wr_end", u_if.wr_window, 1'b0);
        chk("t1_drain", state, 3'd3);
        step(1);
        chk("t1_drain2", state, 3'd3);
        step(1);
        chk("t1_hold", state, 3'd4);
        step(9);
        chk("t1_hold_last", state, 3'd4);
        step(1);
        chk("t1_after_hold", state, EXP_AFTER_HOLD);

        // External trigger, win_len 0 means one cycle
        do_reset();
        trig_sel = 2'b01; win_len = '0;
        step(1);
        chk("t2_armed", state, 3'd1);
        chk("t2_evt_rst", evt_cnt, 16'd0);
        time_in = 40'hAB_CDEF_0123; trig_ext = 1'b1;
        step(3);
        chk("t2_wr_pre", u_if.wr_window, 1'b0);
        step(1);
        chk("t2_wr_on", u_if.wr_window, 1'b1);
        chk("t2_evt", evt_cnt, 16'd1);
        chk("t2_time", evt_time, 40'hAB_CDEF_0123);
        step(1);
        chk("t2_wr_off", u_if.wr_window, 1'b0);
        chk("t2_drain", state, 3'd3);

        // Missed triggers during CAPTURE and HOLDOFF, then saturation
        do_reset();
        trig_ext = 1'b0; trig_sel = 2'b00; win_len = 12'd20; holdoff = 16'd10;
        step(1);
        trig_int = 1'b1;
        step(1);
        trig_int = 1'b0;
        chk("t3_capture", state, 3'd2);
        repeat (3) begin
            trig_int = 1'b1; step(1);
            trig_int = 1'b0; step(1);
        end
        chk("t3_miss_cap", miss_cnt, 8'd3);
        chk("t3_still_cap", state, 3'd2);
        step(14);
        step(2);
        chk("t3_hold", state, 3'd4);
        trig_int = 1'b1; step(1); trig_int = 1'b0;
        chk("t3_miss_hold", miss_cnt, 8'd4);
        chk("t3_evt", evt_cnt, 16'd1);
        step(9);
        chk("t3_after_hold", state, EXP_AFTER_HOLD);
        arm_en = 1'b0;
        step(1);
        chk("t3_idle", state, 3'd0);
        arm_en = 1'b1; trig_int = 1'b1;
        step(1);
        trig_int = 1'b0;
        chk("t3_arm_entry", state, 3'd1);
        chk("t3_entry_not_missed", miss_cnt, 8'd4);
        step(1);
        chk("t3_entry_not_taken", state, 3'd1);
        arm_en = 1'b0;
        step(1);
        repeat (300) begin
            trig_int = 1'b1; step(1);
            trig_int = 1'b0; step(1);
        end
        chk("t3_miss_sat", miss_cnt, 8'hFF);
        chk("t3_evt_after_sat", evt_cnt, 16'd1);
        clr = 1'b1; step(1); clr = 1'b0;
        chk("t3_clr_miss", miss_cnt, 8'd0);
        chk("t3_clr_evt", evt_cnt, 16'd0);

        // Drain timeout with one FIFO stuck empty
        do_reset();
        win_len = 12'd4; holdoff = '0; arm_en = 1'b1;
        step(1);
        trig_int = 1'b1; step(1); trig_int = 1'b0;
        u_if.fifo_ef1 = 1'b0; u_if.fifo_ef2 = 1'b0;
        #1;
        chk("t4_rd_on", u_if.rd_en, 1'b1);
        u_if.fifo_ef1 = 1'b1;
        #1;
        chk("t4_rd_off", u_if.rd_en, 1'b0);
        step(4);
        chk("t4_drain", state, 3'd3);
        chk("t4_drain_rd", u_if.rd_en, 1'b0);
        step(15);
        chk("t4_drain15", state, 3'd3);
        chk("t4_err_pre", err_flag, 1'b0);
        step(1);
        chk("t4_timeout_state", state, 3'd4);
        chk("t4_err", err_flag, 1'b1);
        step(1);
        chk("t4_hold0", state, EXP_AFTER_HOLD);
        chk("t4_err_sticky", err_flag, 1'b1);

        // Overflow during capture, clear, clear with simultaneous trigger
        u_if.fifo_ef1 = 1'b1; u_if.fifo_ef2 = 1'b1;
        rearm();
        chk("t5_armed", state, 3'd1);
        win_len = 12'd8;
        trig_int = 1'b1; step(1); trig_int = 1'b0;
        step(2);
        u_if.fifo_ff2 = 1'b1; step(1); u_if.fifo_ff2 = 1'b0;
        chk("t5_ovf", ovf_flag, 1'b1);
        step(4);
        chk("t5_wr_last", u_if.wr_window, 1'b1);
        step(1);
        chk("t5_wr_end", u_if.wr_window, 1'b0);
        chk("t5_drain", state, 3'd3);
        chk("t5_evt2", evt_cnt, 16'd2);
        clr = 1'b1; step(1); clr = 1'b0;
        chk("t5_clr_evt", evt_cnt, 16'd0);
        chk("t5_clr_flags", {ovf_flag, err_flag}, 2'b00);
        chk("t5_clr_fsm", state, 3'd3);
        step(2);
        rearm();
        clr = 1'b1; trig_int = 1'b1;
        step(1);
        clr = 1'b0; trig_int = 1'b0;
        chk("t5_clr_trig_evt", evt_cnt, 16'd1);
        chk("t5_clr_trig_state", state, 3'd2);

        // Asynchronous reset in the middle of a capture window
        u_if.fifo_ef1 = 1'b0; u_if.fifo_ef2 = 1'b0;
        step(2);
        chk("t6_wr_pre", u_if.wr_window, 1'b1);
        chk("t6_rd_pre", u_if.rd_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_wr_rst", u_if.wr_window, 1'b0);
        chk("t6_rd_rst", u_if.rd_en, 1'b0);
        chk("t6_state_rst", state, 3'd0);
        chk("t6_evt_rst", evt_cnt, 16'd0);
        step(1);
        rst_n = 1'b1;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
